// File: rtl/program_loader.sv
// Boot sequencer for the single-cycle MIPS core: holds the core in reset, streams
// program words into instruction memory, then runs the core for a set number of cycles.
module program_loader #(
  parameter  int WIDTH       = 32,
  parameter  int DEPTH_WORDS = 256,
  parameter  int ADDR_STEP   = 4,
  parameter  int RUN_W       = 16,
  localparam int CNT_W       = $clog2(DEPTH_WORDS) + 1
) (
  input  logic             clock,
  input  logic             reset_in,
  input  logic             start_in,
  input  logic             abort_in,
  input  logic [RUN_W-1:0] run_cycles_in,
  input  logic             word_valid_in,
  input  logic [WIDTH-1:0] word_in,
  input  logic             last_in,
  output logic             word_ready_out,
  output logic             instrWrite_out,
  output logic [WIDTH-1:0] instr_address_out,
  output logic [WIDTH-1:0] instr_out,
  output logic             cpu_reset_out,
  output logic             busy_out,
  output logic             done_out,
  output logic             overflow_err_out,
  output logic [CNT_W-1:0] words_loaded_out
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_RUN    = 3'd3,
    S_DONE   = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [RUN_W-1:0] run_lat_q, run_lat_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic             wr_q, wr_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             cpu_rst_q, cpu_rst_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic handshake;
  logic start_ok;

  // Ready is the only output decoded straight from state.
  assign word_ready_out = (state_q == S_LOAD) && (count_q < CNT_W'(DEPTH_WORDS));
  assign handshake      = word_valid_in & word_ready_out;
  assign start_ok       = start_in &&
                          ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR));

  always_ff @(posedge clock or posedge reset_in) begin
    if (reset_in) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      run_lat_q <= '0;
      run_cnt_q <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      cpu_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      run_lat_q <= run_lat_d;
      run_cnt_q <= run_cnt_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      cpu_rst_q <= cpu_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort_in) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: if (start_in) state_d = S_LOAD;
        S_LOAD: begin
          // last_in wins even on the final slot, so a full-memory program is legal.
          if (handshake) begin
            if (last_in)                                  state_d = S_SETTLE;
            else if (count_q == CNT_W'(DEPTH_WORDS - 1))  state_d = S_ERROR;
          end
        end
        S_SETTLE: state_d = S_RUN;
        S_RUN:    if (run_cnt_q == RUN_W'(1)) state_d = S_DONE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    count_d   = count_q;
    run_lat_d = run_lat_q;
    run_cnt_d = run_cnt_q;
    wr_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    if (!abort_in) begin
      if (start_ok) begin
        count_d   = '0;
        run_lat_d = run_cycles_in;
      end
      if ((state_q == S_LOAD) && handshake) begin
        wr_d    = 1'b1;
        addr_d  = WIDTH'(count_q) * WIDTH'(ADDR_STEP);
        data_d  = word_in;
        count_d = count_q + CNT_W'(1);
      end
      if (state_q == S_SETTLE) run_cnt_d = run_lat_q;
      // A zero count never decrements, which is what makes N=0 free-run.
      if ((state_q == S_RUN) && (run_cnt_q != '0)) run_cnt_d = run_cnt_q - RUN_W'(1);
    end
    cpu_rst_d = (state_d != S_RUN);
    busy_d    = (state_d == S_LOAD) || (state_d == S_SETTLE) || (state_d == S_RUN);
    done_d    = (state_d == S_DONE);
    err_d     = (state_d == S_ERROR);
  end

  assign instrWrite_out    = wr_q;
  assign instr_address_out = addr_q;
  assign instr_out         = data_q;
  assign cpu_reset_out     = cpu_rst_q;
  assign busy_out          = busy_q;
  assign done_out          = done_q;
  assign overflow_err_out  = err_q;
  assign words_loaded_out  = count_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: table-driven load/run scenarios plus abort, free-run
// and async-reset sequences; writes are scoreboarded against a queue of expected writes.
module tb_program_loader;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int RUN_W = 16;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_in, abort_in, word_valid_in, last_in;
  logic [RUN_W-1:0] run_cycles_in;
  logic [WIDTH-1:0] word_in;
  logic             word_ready_out, instrWrite_out, cpu_reset_out;
  logic             busy_out, done_out, overflow_err_out;
  logic [WIDTH-1:0] instr_address_out, instr_out;
  logic [CNT_W-1:0] words_loaded_out;

  program_loader #(.WIDTH(WIDTH), .DEPTH_WORDS(DEPTH), .ADDR_STEP(4), .RUN_W(RUN_W)) dut (
    .clock(clk), .reset_in(rst), .start_in(start_in), .abort_in(abort_in),
    .run_cycles_in(run_cycles_in), .word_valid_in(word_valid_in), .word_in(word_in),
    .last_in(last_in), .word_ready_out(word_ready_out), .instrWrite_out(instrWrite_out),
    .instr_address_out(instr_address_out), .instr_out(instr_out),
    .cpu_reset_out(cpu_reset_out), .busy_out(busy_out), .done_out(done_out),
    .overflow_err_out(overflow_err_out), .words_loaded_out(words_loaded_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;
  wr_t sb[$];

  typedef struct {
    int               n;
    bit               gap;
    bit               last;
    logic [15:0]      run;
    logic [3:0][31:0] w;
    int               exp_words;
    bit               exp_err;
    int               exp_lows;
  } vec_t;
  vec_t tbl[4];

  int checks = 0;
  int failures = 0;
  int pulses = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Every write strobe must match the oldest outstanding accepted word.
  always @(negedge clk) begin
    if (instrWrite_out === 1'b1) begin
      pulses++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_write actual=addr %0h required=no write", instr_address_out);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", instr_address_out, e.a);
        chk("wr_data", instr_out, e.d);
      end
    end
  end

  function automatic vec_t mk(int n, bit gap, bit last, logic [15:0] run,
                              logic [31:0] w0, logic [31:0] w1, logic [31:0] w2,
                              logic [31:0] w3, int ew, bit ee, int el);
    vec_t v;
    v.n = n; v.gap = gap; v.last = last; v.run = run;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    v.exp_words = ew; v.exp_err = ee; v.exp_lows = el;
    return v;
  endfunction

  task automatic begin_load(logic [15:0] run);
    start_in = 1'b1;
    run_cycles_in = run;
    @(negedge clk);
    start_in = 1'b0;
    chk("load_busy", busy_out, 1);
    chk("load_words0", words_loaded_out, 0);
    chk("load_cpu_rst", cpu_reset_out, 1);
    chk("load_ready", word_ready_out, 1);
  endtask

  // Drive one word at a negedge, so the handshake lands on the next posedge.
  task automatic drive_word(int idx, logic [31:0] w, bit last);
    word_valid_in = 1'b1;
    word_in = w;
    last_in = last;
    chk("ready_before_hs", word_ready_out, 1);
    sb.push_back({32'(idx * 4), w});
    @(negedge clk);
    word_valid_in = 1'b0;
    last_in = 1'b0;
  endtask

  task automatic run_vec(vec_t v);
    int p0, lows;
    bit got;
    p0 = pulses;
    begin_load(v.run);
    for (int i = 0; i < v.n; i++) begin
      if (v.gap && i > 0) begin
        @(negedge clk);
        @(negedge clk);
      end
      drive_word(i, v.w[i], v.last && (i == v.n - 1));
    end
    if (!v.exp_err) begin
      chk("settle_cpu_rst", cpu_reset_out, 1);
      chk("settle_busy", busy_out, 1);
      lows = 0;
      got = 1'b0;
      for (int k = 0; k < 300; k++) begin
        @(negedge clk);
        if (done_out) begin
          got = 1'b1;
          break;
        end
        if (!cpu_reset_out) lows++;
      end
      chk("done_seen", 32'(got), 1);
      chk("run_low_cycles", lows, v.exp_lows);
      chk("done_cpu_rst", cpu_reset_out, 1);
      chk("done_busy", busy_out, 0);
    end else begin
      chk("err_flag", overflow_err_out, 1);
      chk("err_ready", word_ready_out, 0);
      chk("err_cpu_rst", cpu_reset_out, 1);
      // The extra word must be refused.
      word_valid_in = 1'b1;
      word_in = 32'hDEADBEEF;
      @(negedge clk);
      word_valid_in = 1'b0;
      chk("err_hold", overflow_err_out, 1);
    end
    chk("words_loaded", words_loaded_out, v.exp_words);
    chk("write_pulses", pulses - p0, v.n);
    chk("sb_empty", sb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int lows;
    tbl[0] = mk(3, 1'b0, 1'b1, 16'd5, 32'h20080005, 32'h20090003, 32'h01095020, 32'h0, 3, 1'b0, 5);
    tbl[1] = mk(4, 1'b1, 1'b1, 16'd2, 32'hA0000001, 32'hB0000002, 32'hC0000003, 32'hD0000004, 4, 1'b0, 2);
    tbl[2] = mk(4, 1'b0, 1'b0, 16'd3, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 4, 1'b1, 0);
    tbl[3] = mk(2, 1'b0, 1'b1, 16'd1, 32'h55AA55AA, 32'h12345678, 32'h0, 32'h0, 2, 1'b0, 1);

    rst = 1'b1; start_in = 1'b0; abort_in = 1'b0; word_valid_in = 1'b0;
    last_in = 1'b0; word_in = '0; run_cycles_in = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_cpu_rst", cpu_reset_out, 1);
    chk("rst_write", instrWrite_out, 0);
    chk("rst_addr", instr_address_out, 0);
    chk("rst_data", instr_out, 0);
    chk("rst_ready", word_ready_out, 0);
    chk("rst_flags", {busy_out, done_out, overflow_err_out}, 0);
    chk("rst_words", words_loaded_out, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", word_ready_out, 0);

    for (int t = 0; t < 4; t++) run_vec(tbl[t]);

    // Abort right after the second handshake, with a third word offered.
    begin_load(16'd4);
    drive_word(0, 32'hCAFE0000, 1'b0);
    drive_word(1, 32'hCAFE0001, 1'b0);
    abort_in = 1'b1;
    word_valid_in = 1'b1;
    word_in = 32'hCAFE0002;
    @(negedge clk);
    abort_in = 1'b0;
    word_valid_in = 1'b0;
    chk("abort_busy", busy_out, 0);
    chk("abort_cpu_rst", cpu_reset_out, 1);
    chk("abort_words", words_loaded_out, 2);
    chk("abort_ready", word_ready_out, 0);
    @(negedge clk);
    chk("abort_sb_empty", sb.size(), 0);

    // Free-run: run_cycles=0 keeps the core out of reset until abort.
    begin_load(16'd0);
    drive_word(0, 32'h00000020, 1'b1);
    lows = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!cpu_reset_out) lows++;
    end
    chk("freerun_lows", lows, 100);
    chk("freerun_done", done_out, 0);
    abort_in = 1'b1;
    @(negedge clk);
    abort_in = 1'b0;
    chk("freerun_abort_rst", cpu_reset_out, 1);
    chk("freerun_abort_busy", busy_out, 0);
    chk("freerun_words", words_loaded_out, 1);

    // Async reset between edges while running.
    begin_load(16'd20);
    drive_word(0, 32'h0BADF00D, 1'b1);
    repeat (3) @(negedge clk);
    chk("pre_rst_running", cpu_reset_out, 0);
    rst = 1'b1;
    #1;
    chk("arst_cpu_rst", cpu_reset_out, 1);
    chk("arst_busy", busy_out, 0);
    chk("arst_write", instrWrite_out, 0);
    chk("arst_words", words_loaded_out, 0);
    chk("arst_addr", instr_address_out, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_vec(tbl[3]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot sequencer for the single-cycle MIPS core.
- Holds the core in reset and streams program words from a valid/ready source into instruction memory over its write port (instrWrite, address, data). It then releases core reset for a programmed number of cycles and re-asserts it.
- Sits between the host/testbench program source and the core's instruction-memory write and reset inputs.

Parameters:
WIDTH, 32, data/address width of instruction memory port
DEPTH_WORDS, 256, instruction memory capacity in words
ADDR_STEP, 4, byte-address increment per word
RUN_W, 16, width of run-cycle counter

Ports:
clock  input  1  system clock, all state on rising edge
reset_in  input  1  asynchronous, active-high reset
start_in  input  1  begin load sequence (sampled in IDLE/DONE/ERROR)
abort_in  input  1  cancel any sequence, return to IDLE
run_cycles_in  input  RUN_W  cycles core runs; sampled when start accepted; 0 = free-run
word_valid_in  input  1  program word available
word_in  input  WIDTH  program word
last_in  input  1  qualifies final word of program
word_ready_out  output  1  loader accepts word this cycle
instrWrite_out  output  1  instruction memory write strobe
instr_address_out  output  WIDTH  byte address of write
instr_out  output  WIDTH  write data
cpu_reset_out  output  1  core reset, active-high
busy_out  output  1  high in LOAD/SETTLE/RUN
done_out  output  1  high in DONE
overflow_err_out  output  1  high in ERROR
words_loaded_out  output  $clog2(DEPTH_WORDS)+1  words written in current/last load

Behaviour:
- Reset (async, reset_in=1): state IDLE; cpu_reset_out=1; instrWrite_out=0; instr_address_out=0; instr_out=0; word_ready_out=0; busy/done/overflow_err=0; words_loaded_out=0; run counter=0.
- All outputs registered; only word_ready_out is decoded from state.
- States: IDLE, LOAD, SETTLE, RUN, DONE, ERROR.
- abort_in has priority over every transition. From any state it causes the following next cycle:
  - state IDLE, instrWrite_out=0, cpu_reset_out=1;
  - words_loaded_out holds its value.
- IDLE:
  - cpu_reset_out=1, word_ready_out=0.
  - start_in=1 causes the following next cycle: state LOAD; word count cleared to 0; run_cycles_in latched.
- LOAD:
  - cpu_reset_out=1; word_ready_out=1 while count<DEPTH_WORDS.
  - Handshake at rising edge with word_valid_in & word_ready_out causes the following next cycle:
    - instrWrite_out=1;
    - instr_address_out=count*ADDR_STEP (WIDTH bits);
    - instr_out=word_in;
    - count increments; words_loaded_out=count+1.
  - Write latency is exactly 1 cycle after the handshake. instrWrite_out is a one-cycle pulse per accepted word. It is 0 in cycles without a handshake.
  - Back-to-back handshakes give back-to-back writes at consecutive addresses. Gaps in word_valid_in are tolerated without limit.
  - Handshake with last_in=1 → SETTLE.
  - Handshake at count=DEPTH_WORDS-1 with last_in=0: that word is still written, then → ERROR (program exceeds memory).
  - start_in is ignored in LOAD.
- SETTLE:
  - One cycle; the final write strobe is presented during it; cpu_reset_out=1.
  - → RUN with run counter loaded from the latched run_cycles value.
- RUN:
  - cpu_reset_out=0, instrWrite_out=0.
  - Latched value N>0: the core is out of reset for exactly N rising edges. Counter decrements each cycle; count 1 → DONE, where cpu_reset_out=1.
  - N=0: stays in RUN until abort_in.
- DONE:
  - done_out=1, cpu_reset_out=1.
  - start_in → LOAD (new load from address 0, run_cycles re-latched).
- ERROR:
  - overflow_err_out=1, cpu_reset_out=1, word_ready_out=0.
  - start_in → LOAD; abort_in → IDLE.
- Asynchronous reset mid-LOAD or mid-RUN: immediate return to reset values. No further write strobe is issued; cpu_reset_out rises asynchronously.
- Zero-word programs cannot be expressed: a load ends only on a handshake with last_in=1.

Test Plan:
- 3-word load and run: start_in with run_cycles_in=5; words 0x20080005, 0x20090003, 0x01095020 (last on 3rd), valid every cycle → writes at 0x0, 0x4, 0x8 on the 3 cycles after each handshake; 1 SETTLE cycle; cpu_reset_out=0 for exactly 5 cycles; done_out=1; words_loaded_out=3.
- Backpressure/gaps: 4 words with word_valid_in toggling 1,0,0,1,… → exactly 4 write pulses at addresses 0x0–0xC; no pulse in gap cycles; data matches input order.
- Overflow with DEPTH_WORDS=4: 5 words, no last_in → 4 writes (0x0–0xC); overflow_err_out=1; word_ready_out=0; cpu_reset_out stays 1; then start_in → LOAD with address restart at 0.
- Abort mid-load: abort_in after 2nd handshake → IDLE next cycle; no further instrWrite_out; cpu_reset_out=1; busy_out=0; words_loaded_out=2.
- Free-run and abort: run_cycles_in=0, 1-word program with last_in → cpu_reset_out=0 indefinitely (check 100 cycles); abort_in → cpu_reset_out=1 next cycle; state IDLE.
- Async reset mid-RUN: assert reset_in between clock edges during RUN → cpu_reset_out=1 and all outputs at reset values before the next edge; after release, start_in is accepted normally.
